// File: rtl/s_box_inverse.sv
// AES inverse S-box: inverse affine transform followed by y^254 in GF(2^8),
// computed iteratively with one square-and-multiply step per clock.
module s_box_inverse (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] idata,
   input  logic       ivalid,
   output logic       iready,
   output logic [7:0] odata,
   output logic       ovalid,
   input  logic       oready
);

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 3;
   localparam logic [W-1:0] EXP   = 8'hFE;
   localparam logic [W-1:0] AFF_C = 8'h05;
   localparam logic [W-1:0] RED   = 8'h1B;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   y, y_nxt;
   logic [W-1:0]   acc, acc_nxt;
   logic [W-1:0]   odata_nxt;
   logic           ovalid_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [W-1:0]   sq, sq_mul, step_val;

   // Shift-and-xor multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] p;
      logic [W-1:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < W; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[W-2:0], 1'b0} ^ (aa[W-1] ? RED : '0);
      end
      return p;
   endfunction

   // Bit i = a[i+2] ^ a[i+5] ^ a[i+7] ^ c[i]; rotate-right forms of those taps.
   function automatic logic [W-1:0] inv_affine(input logic [W-1:0] a);
      return {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ AFF_C;
   endfunction

   assign iready = (state == IDLE) || ((state == DONE) && oready);

   // One MSB-first square-and-multiply step over the fixed exponent.
   always_comb begin
      sq       = gmul(acc, acc);
      sq_mul   = gmul(sq, y);
      step_val = EXP[CW'(W-1) - cnt] ? sq_mul : sq;
   end

   always_comb begin
      state_nxt  = state;
      y_nxt      = y;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      odata_nxt  = odata;
      ovalid_nxt = ovalid;
      case (state)
         IDLE: begin
            if (ivalid) begin
               y_nxt     = inv_affine(idata);
               acc_nxt   = 8'h01;
               cnt_nxt   = '0;
               state_nxt = CALC;
            end
         end
         CALC: begin
            acc_nxt = step_val;
            if (cnt == CW'(W-1)) begin
               odata_nxt  = step_val;
               ovalid_nxt = 1'b1;
               state_nxt  = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            if (oready) begin
               ovalid_nxt = 1'b0;
               state_nxt  = IDLE;
               // Output and input handshakes can share this edge.
               if (ivalid) begin
                  y_nxt     = inv_affine(idata);
                  acc_nxt   = 8'h01;
                  cnt_nxt   = '0;
                  state_nxt = CALC;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y      <= '0;
         acc    <= 8'h01;
         cnt    <= '0;
         odata  <= '0;
         ovalid <= 1'b0;
      end else begin
         y      <= y_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         odata  <= odata_nxt;
         ovalid <= ovalid_nxt;
      end
   end

endmodule

// File: doc/s_box_inverse.md
S_BOX_INVERSE -- requirements
Module: s_box_inverse

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port: idata  input  8  byte to be inverse-substituted.
REQ-004 SHALL have port: ivalid  input  1  idata valid.
REQ-005 SHALL have port: iready  output  1  block can accept idata.
REQ-006 SHALL have port: odata  output  8  AES inverse S-box result.
REQ-007 SHALL have port: ovalid  output  1  odata valid.
REQ-008 SHALL have port: oready  input  1  downstream accepts odata.
REQ-009 SHALL have no parameters; widths are fixed at 8 bits.

Function
REQ-010 SHALL compute odata = InvSubBytes(idata) per FIPS-197, the exact inverse of the team's s_box_forward.
REQ-011 SHALL compute the result without a lookup table: first inverse affine y = InvAffine(idata), with bit i = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8] ^ c[i], c = 8'h05; then odata = y^254 in GF(2^8) mod x^8+x^4+x^3+x+1 (8'h1B reduction), so y=0 yields 0.
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL make input handshake occur on a rising edge with ivalid=1 and iready=1.
REQ-014 SHALL drive iready = (state==IDLE) or (state==DONE and oready=1), combinationally.
REQ-015 SHALL, on input handshake, register y, set acc=8'h01, set step counter to 0, and move to CALC.
REQ-016 SHALL, in CALC, perform one square-and-multiply step per clock, MSB-first over exponent 8'b1111_1110: acc <= acc*acc, then multiplied by y if exponent bit (7-step) is 1.
REQ-017 SHALL use a 3-bit step counter; the step-7 edge SHALL register acc into odata and move to DONE; the counter does not wrap within CALC.
REQ-018 SHALL give fixed latency: ovalid rises exactly 8 clocks after the acceptance edge, independent of data.
REQ-019 SHALL assert ovalid only in DONE.
REQ-020 SHALL, in DONE with oready=0, hold odata and ovalid stable indefinitely and ignore ivalid and idata.
REQ-021 SHALL, in DONE with oready=1 and ivalid=0, complete output handshake and return to IDLE; ovalid falls next cycle.
REQ-022 SHALL, in DONE with oready=1 and ivalid=1, complete both handshakes on the same edge and go directly to CALC with the new byte; sustained throughput is 1 byte per 9 clocks.
REQ-023 SHALL ignore ivalid/idata changes during CALC, with iready=0.
REQ-024 SHALL implement the GF(2^8) multiply as a combinational function, shift-and-xor with 8'h1B reduction, reused for the square and the multiply within one cycle.

Reset
REQ-025 SHALL, while rst=0, hold state=IDLE, odata=8'h00, ovalid=0, acc=8'h01, y=8'h00, counter=0; iready SHALL be 1 during reset.
REQ-026 SHALL abort any computation or held output on rst assertion mid-CALC or mid-DONE, discarding it; after release the first accepted byte SHALL produce a correct result.
REQ-027 SHALL require no synchronous initialisation after release; acceptance is possible on the first clock edge with rst=1.

Verification
REQ-028 SHALL cover single bytes with oready=1: idata 8'hEA -> odata 8'hBB; 8'h9C -> 8'h1C; 8'hB1 -> 8'h56; 8'h63 -> 8'h00; 8'h00 -> 8'h52; each with ovalid rising 8 clocks after acceptance.
REQ-029 SHALL cover round trip: all 256 values through s_box_forward then s_box_inverse -> output equals original byte; plus all 256 direct results against a golden InvSbox table.
REQ-030 SHALL cover backpressure: idata 8'hED accepted, oready=0 for 20 clocks -> odata=8'h53 and ovalid=1 stable throughout, iready=0, idata toggling ignored; oready=1 -> handshake, then return to IDLE.
REQ-031 SHALL cover back-to-back: ivalid=1 and oready=1 held, stream 8'h7C, 8'hEA -> odata 8'h01 then 8'hBB; the second byte is accepted on the same edge as the first output handshake; results 9 clocks apart.
REQ-032 SHALL cover reset mid-operation: rst=0 at step 4 of CALC for 8'h9C -> ovalid=0 and odata=8'h00 immediately, without waiting for a clock edge; after release, 8'hB1 -> 8'h56 with 8-clock latency.
